// File: rtl/wb_io_arbiter.sv
// Round-robin Wishbone N-to-1 arbiter for the IO bus master port.
// Optional stall timeout: define WB_IO_ARBITER_TIMEOUT_EN.
module wb_io_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [32*NUM_MASTERS-1:0] wbm_adr_i,
  input  logic [32*NUM_MASTERS-1:0] wbm_dat_i,
  input  logic [4*NUM_MASTERS-1:0]  wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]    wbm_we_i,
  input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
  input  logic [3*NUM_MASTERS-1:0]  wbm_cti_i,
  input  logic [2*NUM_MASTERS-1:0]  wbm_bte_i,
  output logic [32*NUM_MASTERS-1:0] wbm_dat_o,
  output logic [NUM_MASTERS-1:0]    wbm_ack_o,
  output logic [NUM_MASTERS-1:0]    wbm_err_o,
  output logic [NUM_MASTERS-1:0]    wbm_rty_o,
  output logic [31:0]               wb_io_adr_o,
  output logic [31:0]               wb_io_dat_o,
  output logic [3:0]                wb_io_sel_o,
  output logic                      wb_io_we_o,
  output logic                      wb_io_cyc_o,
  output logic                      wb_io_stb_o,
  output logic [2:0]                wb_io_cti_o,
  output logic [1:0]                wb_io_bte_o,
  input  logic [31:0]               wb_io_dat_i,
  input  logic                      wb_io_ack_i,
  input  logic                      wb_io_err_i,
  input  logic                      wb_io_rty_i
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [IW-1:0] last, last_nxt;
  logic [IW-1:0] pick;
  logic          any_req;
  logic          owned;
  logic          own_cyc;
  logic          own_stb;
  logic          to_kill;
  logic          to_err;

  // Reset drops the grant in the very cycle it is asserted
  assign owned   = (state == OWNED) && !wb_rst_i;
  assign any_req = |wbm_cyc_i;
  assign own_cyc = wbm_cyc_i[owner];
  assign own_stb = wbm_stb_i[owner];

  always_comb begin
    logic found;
    int   idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = (int'(last) + i) % NUM_MASTERS;
      if (!found && wbm_cyc_i[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = OWNED;
          owner_nxt = pick;
        end
      end
      OWNED: begin
        if (!own_cyc) begin
          state_nxt = IDLE;
          last_nxt  = owner;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      owner <= '0;
      last  <= IW'(NUM_MASTERS - 1);
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    wb_io_adr_o = '0;
    wb_io_dat_o = '0;
    wb_io_sel_o = '0;
    wb_io_we_o  = 1'b0;
    wb_io_cyc_o = 1'b0;
    wb_io_stb_o = 1'b0;
    wb_io_cti_o = '0;
    wb_io_bte_o = '0;
    if (owned) begin
      wb_io_adr_o = wbm_adr_i[32*owner +: 32];
      wb_io_dat_o = wbm_dat_i[32*owner +: 32];
      wb_io_sel_o = wbm_sel_i[4*owner +: 4];
      wb_io_we_o  = wbm_we_i[owner];
      wb_io_cyc_o = own_cyc && !to_kill;
      wb_io_stb_o = own_stb && !to_kill;
      wb_io_cti_o = wbm_cti_i[3*owner +: 3];
      wb_io_bte_o = wbm_bte_i[2*owner +: 2];
    end
  end

  assign wbm_dat_o = {NUM_MASTERS{wb_io_dat_i}};

  always_comb begin
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (owned && owner == IW'(k)) begin
        wbm_ack_o[k] = wb_io_ack_i;
        wbm_err_o[k] = wb_io_err_i || to_err;
        wbm_rty_o[k] = wb_io_rty_i;
      end
    end
  end

`ifdef WB_IO_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] stall_cnt;
  logic        resp;

  assign resp = wb_io_ack_i || wb_io_err_i || wb_io_rty_i;

  // Kill is decided from the count alone so stb never depends on ack
  assign to_kill = owned && own_cyc && own_stb &&
                   (stall_cnt == TO_LAST);
  assign to_err  = to_kill && !resp;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stall_cnt <= '0;
    end else if (!owned || !own_cyc || resp || to_kill) begin
      stall_cnt <= '0;
    end else if (own_stb) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign to_kill = 1'b0;
  assign to_err  = 1'b0;
`endif

endmodule

// File: tb/tb_wb_io_arbiter.sv
// Directed-vector bench for wb_io_arbiter with two masters.
// Timeout checks follow WB_IO_ARBITER_TIMEOUT_EN.
module tb_wb_io_arbiter;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [32*N-1:0] wbm_adr_i;
  logic [32*N-1:0] wbm_dat_i;
  logic [4*N-1:0]  wbm_sel_i;
  logic [N-1:0]    wbm_we_i;
  logic [N-1:0]    wbm_cyc_i;
  logic [N-1:0]    wbm_stb_i;
  logic [3*N-1:0]  wbm_cti_i;
  logic [2*N-1:0]  wbm_bte_i;
  logic [32*N-1:0] wbm_dat_o;
  logic [N-1:0]    wbm_ack_o;
  logic [N-1:0]    wbm_err_o;
  logic [N-1:0]    wbm_rty_o;
  logic [31:0]     io_adr;
  logic [31:0]     io_dat_o;
  logic [3:0]      io_sel;
  logic            io_we;
  logic            io_cyc;
  logic            io_stb;
  logic [2:0]      io_cti;
  logic [1:0]      io_bte;
  logic [31:0]     io_dat_i;
  logic            io_ack;
  logic            io_err;
  logic            io_rty;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_io_arbiter #(
    .NUM_MASTERS(N),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .wbm_adr_i(wbm_adr_i),
    .wbm_dat_i(wbm_dat_i),
    .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i),
    .wbm_cyc_i(wbm_cyc_i),
    .wbm_stb_i(wbm_stb_i),
    .wbm_cti_i(wbm_cti_i),
    .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_o(wbm_ack_o),
    .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o),
    .wb_io_adr_o(io_adr),
    .wb_io_dat_o(io_dat_o),
    .wb_io_sel_o(io_sel),
    .wb_io_we_o(io_we),
    .wb_io_cyc_o(io_cyc),
    .wb_io_stb_o(io_stb),
    .wb_io_cti_o(io_cti),
    .wb_io_bte_o(io_bte),
    .wb_io_dat_i(io_dat_i),
    .wb_io_ack_i(io_ack),
    .wb_io_err_i(io_err),
    .wb_io_rty_i(io_rty)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int m, input logic on,
                     input logic [31:0] adr,
                     input logic [2:0] cti);
    wbm_cyc_i[m]          = on;
    wbm_stb_i[m]          = on;
    wbm_adr_i[32*m +: 32] = adr;
    wbm_cti_i[3*m +: 3]   = cti;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int errs;
    rst       = 1'b1;
    wbm_adr_i = '0;
    wbm_dat_i = {32'hB1B1_B1B1, 32'hA0A0_A0A0};
    wbm_sel_i = '1;
    wbm_we_i  = '0;
    wbm_cyc_i = '0;
    wbm_stb_i = '0;
    wbm_cti_i = '0;
    wbm_bte_i = '0;
    io_dat_i  = '0;
    io_ack    = 1'b0;
    io_err    = 1'b0;
    io_rty    = 1'b0;

    tick();
    tick();
    chk("rst_cyc", 32'(io_cyc), 32'd0);
    chk("rst_adr", io_adr, 32'd0);
    chk("rst_ack", 32'(wbm_ack_o), 32'd0);
    rst = 1'b0;

    // 1: single read by master 0
    req(0, 1'b1, 32'h0000_1000, 3'b000);
    #1 chk("t1_stb_lat0", 32'(io_stb), 32'd0);
    tick();
    #1 chk("t1_stb", 32'(io_stb), 32'd1);
    chk("t1_adr", io_adr, 32'h0000_1000);
    chk("t1_wdat", io_dat_o, 32'hA0A0_A0A0);
    chk("t1_noack", 32'(wbm_ack_o), 32'd0);
    tick();
    io_ack   = 1'b1;
    io_dat_i = 32'hDEAD_BEEF;
    #1 chk("t1_ack", 32'(wbm_ack_o), 32'd1);
    chk("t1_rdat", wbm_dat_o[31:0], 32'hDEAD_BEEF);
    chk("t1_rdat1", wbm_dat_o[63:32], 32'hDEAD_BEEF);
    tick();
    io_ack = 1'b0;
    req(0, 1'b0, 32'h0, 3'b000);
    #1 chk("t1_ack_off", 32'(wbm_ack_o), 32'd0);
    chk("t1_cyc_off", 32'(io_cyc), 32'd0);
    tick();

    // 2: simultaneous requests alternate
    do_reset();
    req(0, 1'b1, 32'h0000_0A00, 3'b000);
    req(1, 1'b1, 32'h0000_0B00, 3'b000);
    tick();
    io_ack = 1'b1;
    #1 chk("t2_own0", io_adr, 32'h0000_0A00);
    chk("t2_ack0", 32'(wbm_ack_o), 32'd1);
    tick();
    io_ack = 1'b0;
    req(0, 1'b0, 32'h0, 3'b000);
    #1 chk("t2_drop", 32'(io_cyc), 32'd0);
    tick();
    #1 chk("t2_gap", 32'(io_cyc), 32'd0);
    tick();
    io_ack = 1'b1;
    #1 chk("t2_own1", io_adr, 32'h0000_0B00);
    chk("t2_ack1", 32'(wbm_ack_o), 32'd2);
    tick();
    io_ack = 1'b0;
    req(1, 1'b0, 32'h0, 3'b000);
    tick();
    req(0, 1'b1, 32'h0000_0A04, 3'b000);
    req(1, 1'b1, 32'h0000_0B04, 3'b000);
    tick();
    #1 chk("t2_alt", io_adr, 32'h0000_0A04);
    req(0, 1'b0, 32'h0, 3'b000);
    req(1, 1'b0, 32'h0, 3'b000);
    tick();
    tick();

    // 3: master 1 burst, master 0 requests mid-burst
    req(1, 1'b1, 32'h0000_2000, 3'b010);
    tick();
    for (int b = 0; b < 4; b++) begin
      req(1, 1'b1, 32'h0000_2000 + 32'(4*b),
          (b == 3) ? 3'b111 : 3'b010);
      if (b == 1) req(0, 1'b1, 32'h0000_3000, 3'b000);
      io_ack = 1'b1;
      #1 chk($sformatf("t3_cyc%0d", b), 32'(io_cyc), 32'd1);
      chk($sformatf("t3_adr%0d", b), io_adr,
          32'h0000_2000 + 32'(4*b));
      chk($sformatf("t3_ack%0d", b), 32'(wbm_ack_o), 32'd2);
      tick();
    end
    io_ack = 1'b0;
    req(1, 1'b0, 32'h0, 3'b000);
    #1 chk("t3_end", 32'(io_cyc), 32'd0);
    tick();
    tick();
    #1 chk("t3_own0", io_adr, 32'h0000_3000);
    req(0, 1'b0, 32'h0, 3'b000);
    tick();
    tick();

    // 4: reset while master 1 owns the bus
    req(1, 1'b1, 32'h0000_4100, 3'b000);
    tick();
    #1 chk("t4_stb1", 32'(io_stb), 32'd1);
    chk("t4_adr1", io_adr, 32'h0000_4100);
    rst = 1'b1;
    req(0, 1'b1, 32'h0000_4000, 3'b000);
    tick();
    rst    = 1'b0;
    io_ack = 1'b1;
    #1 chk("t4_cyc", 32'(io_cyc), 32'd0);
    chk("t4_noack", 32'(wbm_ack_o), 32'd0);
    tick();
    io_ack = 1'b0;
    #1 chk("t4_own0", io_adr, 32'h0000_4000);
    req(0, 1'b0, 32'h0, 3'b000);
    req(1, 1'b0, 32'h0, 3'b000);
    tick();
    tick();

    // 5: error response holds ownership until cyc drops
    req(0, 1'b1, 32'hF000_0000, 3'b000);
    tick();
    io_err = 1'b1;
    #1 chk("t5_err", 32'(wbm_err_o), 32'd1);
    chk("t5_noack", 32'(wbm_ack_o), 32'd0);
    tick();
    io_err       = 1'b0;
    wbm_stb_i[0] = 1'b0;
    #1 chk("t5_err_off", 32'(wbm_err_o), 32'd0);
    chk("t5_hold", 32'(io_cyc), 32'd1);
    tick();
    #1 chk("t5_hold2", 32'(io_cyc), 32'd1);
    req(0, 1'b0, 32'h0, 3'b000);
    #1 chk("t5_rel", 32'(io_cyc), 32'd0);
    tick();
    tick();

    // 6: silent slave
    req(1, 1'b1, 32'h0000_5000, 3'b000);
    tick();
`ifdef WB_IO_ARBITER_TIMEOUT_EN
    for (int k = 1; k <= 7; k++) begin
      #1 chk($sformatf("t6_stall%0d", k), 32'(wbm_err_o), 32'd0);
      tick();
    end
    #1 chk("t6_to_err", 32'(wbm_err_o), 32'd2);
    chk("t6_to_stb", 32'(io_stb), 32'd0);
    chk("t6_to_cyc", 32'(io_cyc), 32'd0);
    tick();
    #1 chk("t6_after_err", 32'(wbm_err_o), 32'd0);
    chk("t6_after_stb", 32'(io_stb), 32'd1);
`else
    errs = 0;
    for (int k = 0; k < 1000; k++) begin
      if (wbm_err_o != '0) errs++;
      tick();
    end
    chk("t6_no_err", 32'(errs), 32'd0);
    chk("t6_stalled", 32'(io_stb), 32'd1);
`endif
    req(1, 1'b0, 32'h0, 3'b000);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_io_arbiter.md
Name: wb_io_arbiter

Overview:
Wishbone N-to-1 master arbiter in front of the IO interconnect's master port (wb_io_*).
Shares the single IO bus between the CPU data master and additional bus masters (e.g. LiDAR capture DMA).
Round-robin arbitration; the grant is locked for the whole cyc of the owning master, so burst/locked accesses to ROM, UART, GPIO, PTC, SPI, VGA and servo slaves are never split.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8).
TIMEOUT_CYCLES, 255, stall cycles before a bus-timeout error is returned (optional feature only; 1..65535).

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  synchronous active-high reset
wbm_adr_i  in  32*NUM_MASTERS  master addresses, master k at [32k+31:32k]
wbm_dat_i  in  32*NUM_MASTERS  master write data
wbm_sel_i  in  4*NUM_MASTERS  byte selects
wbm_we_i  in  NUM_MASTERS  write enables
wbm_cyc_i  in  NUM_MASTERS  cycle / request
wbm_stb_i  in  NUM_MASTERS  strobes
wbm_cti_i  in  3*NUM_MASTERS  cycle type
wbm_bte_i  in  2*NUM_MASTERS  burst type
wbm_dat_o  out  32*NUM_MASTERS  read data (slave data broadcast to all)
wbm_ack_o  out  NUM_MASTERS  ack, owner only
wbm_err_o  out  NUM_MASTERS  err, owner only
wbm_rty_o  out  NUM_MASTERS  rty, owner only
wb_io_adr_o  out  32  to IO interconnect
wb_io_dat_o  out  32  write data to IO interconnect
wb_io_sel_o  out  4  byte selects
wb_io_we_o  out  1  write enable
wb_io_cyc_o  out  1  cycle
wb_io_stb_o  out  1  strobe
wb_io_cti_o  out  3  cycle type
wb_io_bte_o  out  2  burst type
wb_io_dat_i  in  32  read data from IO interconnect
wb_io_ack_i  in  1  ack
wb_io_err_i  in  1  err
wb_io_rty_i  in  1  rty

Behaviour:
- States: IDLE, OWNED. Registers: owner (clog2 index), last (index), state.
- Reset: state=IDLE, last=NUM_MASTERS-1 (master 0 wins the first tie). All wb_io_* outputs are 0. All wbm_ack/err/rty_o are 0. Reset mid-transaction drops the grant immediately, with no ack.
- IDLE: if any wbm_cyc_i is high, owner = first requester scanning last+1, last+2, ... modulo NUM_MASTERS. Go to OWNED on the next edge. Grant latency is 1 cycle, so the earliest wb_io_stb_o is the cycle after the request.
- OWNED: wb_io_* outputs are the owner's signals (combinational mux). wb_io_cyc_o/stb_o are gated by state==OWNED.
- OWNED: wbm_ack/err/rty_o[owner] = wb_io_ack/err/rty_i (combinational, zero added latency). Non-owners receive 0.
- OWNED exit: when wbm_cyc_i[owner]==0 -> IDLE, last=owner, wb_io_cyc_o low that same cycle. The minimum idle gap between owners is 1 cycle.
- Requests from non-owners while OWNED are held pending. There is no preemption. Fairness: with all masters requesting continuously, each is granted once per NUM_MASTERS grants.
- A request whose cyc falls before the grant is taken is simply not granted; there is no latching of requests.
- In IDLE, wbm_dat_o is still wb_io_dat_i, but no ack/err/rty is forwarded.

Optional Feature:
- Macro: WB_IO_ARBITER_TIMEOUT_EN.
- Defined:
  - A 16-bit stall counter increments each OWNED cycle with wb_io_stb_o=1 and no ack/err/rty.
  - The counter clears on any response, on exit from OWNED, and on reset.
  - When the counter reaches TIMEOUT_CYCLES, wbm_err_o[owner] pulses for 1 cycle, wb_io_stb_o/cyc_o are forced to 0 in that cycle, and the counter clears.
  - A real ack arriving in the timeout cycle takes priority, and err is not asserted.
- Undefined: no counter is present, and a non-responding slave stalls the bus indefinitely.

Test Plan:
1. Reset, then master 0 single read of 0x00001000 with slave ack on its 2nd stb cycle -> wb_io_stb_o rises 1 cycle after cyc0; wbm_ack_o=2'b01 for exactly 1 cycle; dat 0xDEADBEEF returned.
2. Both masters raise cyc in the same cycle after reset -> master 0 is granted first; after cyc0 falls, 1 idle cycle, then master 1 is granted; the next simultaneous request goes to master 0 again (alternation).
3. Master 1 does a 4-beat incrementing burst (cti=3'b010, then 3'b111) to 0x00002000 while master 0 requests mid-burst -> all 4 beats complete with owner=1 and no wb_io_cyc_o drop; master 0 is granted only afterwards.
4. wb_rst_i is asserted for 1 cycle while owner=1 has stb high -> the next cycle has wb_io_cyc_o=0 and no ack to master 1; the following grant goes to master 0.
5. wb_io_err_i is returned for an unmapped address -> wbm_err_o[owner]=1 and no ack; the arbiter stays OWNED until the master drops cyc.
6. (WB_IO_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=8) slave never acks -> wbm_err_o[owner] pulses on the 8th stall cycle with wb_io_stb_o=0 in that cycle; without the macro there is no err after 1000 cycles.
